fu_matrix_ls_engine: RTL and testbench
======================================

# fu_matrix_ls_engine

Sequential, parametrised matrix load/store functional unit. Accepts one matrix load or store instruction, then issues one memory request per matrix row at `base + r*stride`, tracks outstanding requests, and writes load rows back to the matrix register file. It replaces the single-cycle address-only matrix LS unit and sits between the dispatch stage and the scratchpad/memory port.

## Interface
Parameters:
- `ROWS`, 4: rows per matrix, power of two, ≥2.
- `ROW_W`, 64: bits per row (4×fp16).
- `ADDR_W`, 32: byte-address width.
- `RD_W`, 4: matrix register index width.
- `MAX_OUT`, 2: maximum outstanding memory requests, 1..ROWS.
- `ROW_BYTES`, 8: default row stride in bytes.

Ports:
- `CLK` in 1: clock, rising edge.
- `nRST` in 1: asynchronous, active-low reset.
- `in_valid` in 1 / `in_ready` out 1: instruction handshake.
- `in_op` in 1: 0 = M_LOAD, 1 = M_STORE (`matrix_mem_t`).
- `in_rd` in RD_W: matrix register, destination for loads and source for stores.
- `in_rs`, `in_imm`, `in_stride` in ADDR_W: base register, offset, row stride.
- `mem_req_valid` out 1 / `mem_req_ready` in 1: request handshake.
- `mem_req_write` out 1, `mem_req_addr` out ADDR_W, `mem_req_wdata` out ROW_W.
- `mem_resp_valid` in 1, `mem_resp_rdata` in ROW_W: in-order responses. Stores also receive a response (ack).
- `st_rd` out RD_W, `st_row` out log2(ROWS), `st_row_data` in ROW_W: combinational matrix register file read port.
- `wb_en` out 1, `wb_rd` out RD_W, `wb_row` out log2(ROWS), `wb_data` out ROW_W: load write-back.
- `busy` out 1, `done` out 1.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`, latch op, rd, base=`in_rs+in_imm` (mod 2^ADDR_W) and stride, clear counters, then go to RUN.
- **RUN**
  - Issue counter `iss` and response counter `rsp` each run 0..ROWS.
  - Outstanding count `out = iss - rsp`.
  - `mem_req_valid` = (`iss<ROWS`) && (`out<MAX_OUT`).
  - `mem_req_addr` = base + `iss`*stride, truncated to ADDR_W (wraps).
  - `iss` increments on the valid&ready handshake.
  - On a `mem_resp_valid` with `out>0`, `rsp` increments. A response with `out==0` is a protocol violation: it is ignored and not counted.
  - Issue and response in the same cycle are both counted, so `out` is unchanged.
  - Stores: `st_rd`=rd, `st_row`=`iss`, and `mem_req_wdata`=`st_row_data`.
  - Loads: `mem_req_wdata`=0.
  - When `rsp` reaches ROWS, go to DONE.
- **DONE**
  - `done`=1 for exactly one cycle, then IDLE.
  - `in_ready`=0 in DONE.
- `busy`=1 in RUN and DONE.
- Load write-back: each counted load response produces `wb_en`=1 with `wb_row`=`rsp` (pre-increment), `wb_rd`=rd, `wb_data`=rdata. Stores never assert `wb_en`.

## Timing
- All outputs are registered except `mem_req_*` and `st_*`, which are decoded from registered state and counters.
- Reset values: state=IDLE, counters=0, `in_ready`=1, `mem_req_valid`=0, `mem_req_write`=0, `mem_req_addr`=0, `mem_req_wdata`=0, `st_rd`=0, `st_row`=0, `wb_en`=0, `wb_rd`=0, `wb_row`=0, `wb_data`=0, `busy`=0, `done`=0.
- Instruction accepted in cycle 0 → first `mem_req_valid` in cycle 1.
- `wb_*` appear the cycle after the corresponding response.
- `done` appears the cycle after the final counted response; for loads this is the same cycle as the last `wb_en`.
- Request stability: while valid && !ready, addr/write/wdata are held. `st_row_data` must stay stable because `iss` is unchanged.
- Best case with `MAX_OUT=ROWS`, ready always 1, zero-latency responses: ROWS+2 cycles from accept to `done`.
- `nRST` asserted mid-operation aborts immediately. In-flight responses after reset are ignored as protocol violations, because `out==0`.

## Configuration
- Macro `FU_MATRIX_LS_STRIDE_EN`.
- Defined: the stride is latched from `in_stride`. A stride of 0 is legal (all rows use the same address).
- Undefined: `in_stride` is unused and the stride is fixed to `ROW_BYTES`.

## Structure
- `matrix_mem_t` (M_LOAD/M_STORE) and the `ROW_BYTES` default belong in `datapath_pkg`.
- The state enum is local to this module.
- One natural sub-module, `mls_addr_gen`:
  - Holds the base/stride latch and a running address accumulator.
  - The accumulator adds stride on each issue, which avoids a multiplier.

## Test plan
- **Load, contiguous:** rs=0x1000, imm=0x10, ROWS=4, ready=1, 1-cycle responses → addrs 0x1010/18/20/28; `wb_row` 0..3 carry the rdata; `done` one cycle after the 4th response.
- **Store, strided** (macro on): stride=0x40, base 0x2000 → addrs 0x2000/40/80/C0; `mem_req_write`=1; wdata equals `st_row_data` for `st_row`=0..3; no `wb_en`.
- **Backpressure with MAX_OUT=2:** `mem_req_ready` toggles and responses are delayed 5 cycles → never more than 2 outstanding; addr held stable while stalled; still exactly 4 `wb_en` pulses.
- **Wrap-around:** base=0xFFFF_FFF8, stride 8 → addrs 0xFFFFFFF8, 0x0, 0x8, 0x10.
- **Simultaneous events:** issue handshake and response in the same cycle → `out` unchanged. A spurious `mem_resp_valid` in IDLE is ignored: no `wb_en`, no `done`.
- **Reset mid-RUN:** after 2 issues, pulse `nRST` low → all outputs at reset values; `in_ready`=1; the next instruction restarts from row 0.

Source files
------------

// File: rtl/fu_matrix_ls_engine_pkg.sv
// Shared datapath types for the matrix load/store engine.
package datapath_pkg;
  typedef enum logic {M_LOAD = 1'b0, M_STORE = 1'b1} matrix_mem_t;

  localparam int unsigned MLS_ROW_BYTES = 8;
endpackage

// File: rtl/fu_matrix_ls_engine_if.sv
// Dispatch, memory-port, register-file and write-back bundle of the matrix LS engine.
interface fu_matrix_ls_engine_if
  import datapath_pkg::*;
#(
  parameter int ROWS   = 4,
  parameter int ROW_W  = 64,
  parameter int ADDR_W = 32,
  parameter int RD_W   = 4
);
  localparam int ROW_IW = $clog2(ROWS);

  logic                in_valid;
  logic                in_ready;
  matrix_mem_t         in_op;
  logic [RD_W-1:0]     in_rd;
  logic [ADDR_W-1:0]   in_rs;
  logic [ADDR_W-1:0]   in_imm;
  logic [ADDR_W-1:0]   in_stride;

  logic                mem_req_valid;
  logic                mem_req_ready;
  logic                mem_req_write;
  logic [ADDR_W-1:0]   mem_req_addr;
  logic [ROW_W-1:0]    mem_req_wdata;
  logic                mem_resp_valid;
  logic [ROW_W-1:0]    mem_resp_rdata;

  logic [RD_W-1:0]     st_rd;
  logic [ROW_IW-1:0]   st_row;
  logic [ROW_W-1:0]    st_row_data;

  logic                wb_en;
  logic [RD_W-1:0]     wb_rd;
  logic [ROW_IW-1:0]   wb_row;
  logic [ROW_W-1:0]    wb_data;

  logic                busy;
  logic                done;

  // Engine side.
  modport slave (
    input  in_valid, in_op, in_rd, in_rs, in_imm, in_stride,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata, st_row_data,
    output in_ready, mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata,
    output st_rd, st_row, wb_en, wb_rd, wb_row, wb_data, busy, done
  );

  // Dispatch / memory / register-file side.
  modport master (
    output in_valid, in_op, in_rd, in_rs, in_imm, in_stride,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata, st_row_data,
    input  in_ready, mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata,
    input  st_rd, st_row, wb_en, wb_rd, wb_row, wb_data, busy, done
  );
endinterface

// File: rtl/fu_matrix_ls_engine_addr_gen.sv
// Row address generator: latches base/stride and steps an accumulator per issued row.
module mls_addr_gen #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [ADDR_W-1:0] stride_i,
  input  logic              step_i,
  output logic [ADDR_W-1:0] addr_o
);
  logic [ADDR_W-1:0] stride_q;
  logic [ADDR_W-1:0] addr_q;

  // Running sum replaces base + row*stride; wraps modulo 2^ADDR_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stride_q <= '0;
      addr_q   <= '0;
    end else if (load_i) begin
      stride_q <= stride_i;
      addr_q   <= base_i;
    end else if (step_i) begin
      addr_q   <= addr_q + stride_q;
    end
  end

  assign addr_o = addr_q;
endmodule

// File: rtl/fu_matrix_ls_engine.sv
// Matrix load/store engine: one memory request per row, in-order responses, load write-back.
// FU_MATRIX_LS_STRIDE_EN: take the row stride from in_stride instead of ROW_BYTES.
module fu_matrix_ls_engine
  import datapath_pkg::*;
#(
  parameter int ROWS      = 4,
  parameter int ROW_W     = 64,
  parameter int ADDR_W    = 32,
  parameter int RD_W      = 4,
  parameter int MAX_OUT   = 2,
  parameter int ROW_BYTES = MLS_ROW_BYTES
) (
  input  logic                 CLK,
  input  logic                 nRST,
  fu_matrix_ls_engine_if.slave bus
);
  localparam int ROW_IW = $clog2(ROWS);
  localparam int CW     = ROW_IW + 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     iss_q, rsp_q, out_w;
  matrix_mem_t       op_q;
  logic [RD_W-1:0]   rd_q;
  logic              accept, req_valid, req_fire, resp_cnt;
  logic [ADDR_W-1:0] acc_addr, stride_in;

  logic              wb_en_q;
  logic [RD_W-1:0]   wb_rd_q;
  logic [ROW_IW-1:0] wb_row_q;
  logic [ROW_W-1:0]  wb_data_q;

`ifdef FU_MATRIX_LS_STRIDE_EN
  assign stride_in = bus.in_stride;
`else
  assign stride_in = ADDR_W'(ROW_BYTES);
`endif

  assign accept    = (state_q == S_IDLE) && bus.in_valid;
  assign out_w     = iss_q - rsp_q;
  assign req_valid = (state_q == S_RUN) && (iss_q < CW'(ROWS)) && (out_w < CW'(MAX_OUT));
  assign req_fire  = req_valid && bus.mem_req_ready;
  // A response with nothing outstanding is a protocol violation and is dropped.
  assign resp_cnt  = (state_q == S_RUN) && bus.mem_resp_valid && (out_w != '0);

  mls_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk      (CLK),
    .rst_n    (nRST),
    .load_i   (accept),
    .base_i   (bus.in_rs + bus.in_imm),
    .stride_i (stride_in),
    .step_i   (req_fire),
    .addr_o   (acc_addr)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.in_valid) state_d = S_RUN;
      S_RUN:  if (resp_cnt && (rsp_q == CW'(ROWS - 1))) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready      = (state_q == S_IDLE);
    bus.busy          = (state_q != S_IDLE);
    bus.done          = (state_q == S_DONE);
    bus.mem_req_valid = req_valid;
    bus.mem_req_write = (state_q == S_RUN) && (op_q == M_STORE);
    bus.mem_req_addr  = (state_q == S_RUN) ? acc_addr : '0;
    bus.mem_req_wdata = ((state_q == S_RUN) && (op_q == M_STORE)) ? bus.st_row_data : '0;
    bus.st_rd         = rd_q;
    bus.st_row        = iss_q[ROW_IW-1:0];
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      iss_q <= '0;
      rsp_q <= '0;
      op_q  <= M_LOAD;
      rd_q  <= '0;
    end else if (accept) begin
      iss_q <= '0;
      rsp_q <= '0;
      op_q  <= bus.in_op;
      rd_q  <= bus.in_rd;
    end else begin
      if (req_fire) iss_q <= iss_q + CW'(1);
      if (resp_cnt) rsp_q <= rsp_q + CW'(1);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wb_en_q   <= 1'b0;
      wb_rd_q   <= '0;
      wb_row_q  <= '0;
      wb_data_q <= '0;
    end else begin
      wb_en_q <= resp_cnt && (op_q == M_LOAD);
      if (resp_cnt && (op_q == M_LOAD)) begin
        wb_rd_q   <= rd_q;
        wb_row_q  <= rsp_q[ROW_IW-1:0];
        wb_data_q <= bus.mem_resp_rdata;
      end
    end
  end

  assign bus.wb_en   = wb_en_q;
  assign bus.wb_rd   = wb_rd_q;
  assign bus.wb_row  = wb_row_q;
  assign bus.wb_data = wb_data_q;
endmodule

// File: tb/tb_fu_matrix_ls_engine.sv
// Directed table-driven bench for fu_matrix_ls_engine with a latency-configurable memory model.
module tb_fu_matrix_ls_engine;
  import datapath_pkg::*;

  localparam int ROWS = 4, ROW_W = 64, ADDR_W = 32, RD_W = 4, MAX_OUT = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fu_matrix_ls_engine_if #(.ROWS(ROWS), .ROW_W(ROW_W), .ADDR_W(ADDR_W), .RD_W(RD_W)) bus ();

  fu_matrix_ls_engine #(
    .ROWS(ROWS), .ROW_W(ROW_W), .ADDR_W(ADDR_W), .RD_W(RD_W), .MAX_OUT(MAX_OUT), .ROW_BYTES(8)
  ) dut (
    .CLK  (clk),
    .nRST (rst_n),
    .bus  (bus)
  );

  function automatic logic [63:0] rf_row(input logic [3:0] rd, input logic [1:0] row);
    return {16'hC0DE, 12'h000, rd, 30'h0, row};
  endfunction

  assign bus.st_row_data = rf_row(bus.st_rd, bus.st_row);

  typedef struct {
    logic             op;
    logic [3:0]       rd;
    logic [31:0]      rs, imm, stride;
    int               lat;
    bit               toggle;
    logic [3:0][31:0] a;
  } vec_t;

  vec_t vecs[5];
  int errs = 0;
  int checks = 0;

  function automatic vec_t mkv(input logic op, input logic [3:0] rd, input logic [31:0] rs,
                               input logic [31:0] imm, input logic [31:0] stride, input int lat,
                               input bit toggle, input logic [31:0] a0, input logic [31:0] a1,
                               input logic [31:0] a2, input logic [31:0] a3);
    vec_t v;
    v.op = op; v.rd = rd; v.rs = rs; v.imm = imm; v.stride = stride;
    v.lat = lat; v.toggle = toggle;
    v.a[0] = a0; v.a[1] = a1; v.a[2] = a2; v.a[3] = a3;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_in_ready"},  64'(bus.in_ready), 64'(1));
    chk({tag, "_req_valid"}, 64'(bus.mem_req_valid), 64'(0));
    chk({tag, "_req_write"}, 64'(bus.mem_req_write), 64'(0));
    chk({tag, "_req_addr"},  64'(bus.mem_req_addr), 64'(0));
    chk({tag, "_req_wdata"}, bus.mem_req_wdata, 64'(0));
    chk({tag, "_st_rd"},     64'(bus.st_rd), 64'(0));
    chk({tag, "_st_row"},    64'(bus.st_row), 64'(0));
    chk({tag, "_wb_en"},     64'(bus.wb_en), 64'(0));
    chk({tag, "_wb_rd"},     64'(bus.wb_rd), 64'(0));
    chk({tag, "_wb_row"},    64'(bus.wb_row), 64'(0));
    chk({tag, "_wb_data"},   bus.wb_data, 64'(0));
    chk({tag, "_busy"},      64'(bus.busy), 64'(0));
    chk({tag, "_done"},      64'(bus.done), 64'(0));
  endtask

  task automatic accept_instr(input vec_t v);
    @(negedge clk);
    chk("accept_in_ready", 64'(bus.in_ready), 64'(1));
    bus.in_valid  = 1'b1;
    bus.in_op     = matrix_mem_t'(v.op);
    bus.in_rd     = v.rd;
    bus.in_rs     = v.rs;
    bus.in_imm    = v.imm;
    bus.in_stride = v.stride;
    @(negedge clk);
    bus.in_valid  = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int iss_m, rsp_m, p_row, nwb;
    int due_q[$];
    logic [31:0] adr_q[$];
    logic [63:0] p_data;
    bit p_cnt, p_last, fin, exp_v, rdy;
    iss_m = 0; rsp_m = 0; p_row = 0; nwb = 0;
    p_cnt = 0; p_last = 0; fin = 0; p_data = '0;
    accept_instr(v);
    for (int cyc = 1; cyc < 200 && !fin; cyc++) begin
      if (bus.wb_en) nwb++;
      chk("wb_en", 64'(bus.wb_en), 64'(p_cnt && !v.op));
      if (p_cnt && !v.op) begin
        chk("wb_row",  64'(bus.wb_row), 64'(p_row));
        chk("wb_rd",   64'(bus.wb_rd), 64'(v.rd));
        chk("wb_data", bus.wb_data, p_data);
      end
      chk("done", 64'(bus.done), 64'(p_last));
      if (p_last) begin
        chk("done_in_ready", 64'(bus.in_ready), 64'(0));
        chk("done_busy", 64'(bus.busy), 64'(1));
        fin = 1;
      end else begin
        exp_v = (iss_m < ROWS) && ((iss_m - rsp_m) < MAX_OUT);
        chk("req_valid", 64'(bus.mem_req_valid), 64'(exp_v));
        if (exp_v) begin
          chk("req_addr",  64'(bus.mem_req_addr), 64'(v.a[iss_m]));
          chk("req_write", 64'(bus.mem_req_write), 64'(v.op));
          chk("req_wdata", bus.mem_req_wdata, v.op ? rf_row(v.rd, 2'(iss_m)) : 64'(0));
        end
        rdy = v.toggle ? (cyc % 2 == 1) : 1'b1;
        bus.mem_req_ready = rdy;
        p_cnt = 0; p_last = 0;
        if (due_q.size() > 0 && due_q[0] <= cyc) begin
          bus.mem_resp_valid = 1'b1;
          bus.mem_resp_rdata = {32'hDA7A_0000, adr_q[0]};
          p_data = {32'hDA7A_0000, adr_q[0]};
          void'(due_q.pop_front());
          void'(adr_q.pop_front());
          p_cnt = 1; p_row = rsp_m; rsp_m++;
          p_last = (rsp_m == ROWS);
        end else begin
          bus.mem_resp_valid = 1'b0;
        end
        if (exp_v && rdy) begin
          due_q.push_back(cyc + v.lat);
          adr_q.push_back(v.a[iss_m]);
          iss_m++;
        end
        @(negedge clk);
      end
    end
    bus.mem_resp_valid = 1'b0;
    bus.mem_req_ready  = 1'b0;
    if (!fin) begin
      checks++; errs++;
      $display("FAIL timeout: done never seen, got rsp=%0d expected %0d", rsp_m, ROWS);
    end
    chk("wb_count", 64'(nwb), v.op ? 64'(0) : 64'(ROWS));
    @(negedge clk);
    chk("post_in_ready", 64'(bus.in_ready), 64'(1));
    chk("post_busy", 64'(bus.busy), 64'(0));
    chk("post_done", 64'(bus.done), 64'(0));
  endtask

  initial begin
    bus.in_valid = 0; bus.in_op = M_LOAD; bus.in_rd = '0; bus.in_rs = '0;
    bus.in_imm = '0; bus.in_stride = '0; bus.mem_req_ready = 0;
    bus.mem_resp_valid = 0; bus.mem_resp_rdata = '0;

    vecs[0] = mkv(1'b0, 4'd3, 32'h1000, 32'h10, 32'h8, 1, 1'b0,
                  32'h1010, 32'h1018, 32'h1020, 32'h1028);
`ifdef FU_MATRIX_LS_STRIDE_EN
    vecs[1] = mkv(1'b1, 4'd7, 32'h2000, 32'h0, 32'h40, 1, 1'b0,
                  32'h2000, 32'h2040, 32'h2080, 32'h20C0);
`else
    vecs[1] = mkv(1'b1, 4'd7, 32'h2000, 32'h0, 32'h40, 1, 1'b0,
                  32'h2000, 32'h2008, 32'h2010, 32'h2018);
`endif
    vecs[2] = mkv(1'b0, 4'd1, 32'h3000, 32'h100, 32'h8, 5, 1'b1,
                  32'h3100, 32'h3108, 32'h3110, 32'h3118);
    vecs[3] = mkv(1'b0, 4'd12, 32'hFFFF_FFF0, 32'h8, 32'h8, 1, 1'b0,
                  32'hFFFF_FFF8, 32'h0000_0000, 32'h0000_0008, 32'h0000_0010);
    vecs[4] = mkv(1'b1, 4'd9, 32'h5000, 32'h20, 32'h8, 2, 1'b1,
                  32'h5020, 32'h5028, 32'h5030, 32'h5038);

    #23;
    check_reset("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Stray response while idle must not produce write-back or completion.
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    chk("idle_resp_wb_en", 64'(bus.wb_en), 64'(0));
    chk("idle_resp_done",  64'(bus.done), 64'(0));
    chk("idle_resp_busy",  64'(bus.busy), 64'(0));
    @(negedge clk);
    chk("idle_resp_wb_en2", 64'(bus.wb_en), 64'(0));

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Reset in the middle of a load after two issues.
    accept_instr(vecs[2]);
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("mid_stalled_valid", 64'(bus.mem_req_valid), 64'(0));
    chk("mid_busy", 64'(bus.busy), 64'(1));
    rst_n = 1'b0;
    #1;
    check_reset("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    bus.mem_req_ready = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = 64'h1111_2222_3333_4444;
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    chk("stale_resp_wb_en", 64'(bus.wb_en), 64'(0));
    chk("stale_resp_done",  64'(bus.done), 64'(0));
    run_vec(vecs[0]);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
